// File: rtl/debug_pkg.sv
// Shared definitions for the debug link: frame layout constants and
// state encodings used by the dump transmitter and its byte serializer.
package debug_pkg;

    // First byte of every dump frame; not covered by the checksum.
    localparam logic [7:0] DBG_FRAME_HEADER = 8'hA5;

    // Frame byte order: header, NUM_WORDS words MSB first, checksum.
    localparam int DBG_HEADER_BYTES   = 1;
    localparam int DBG_BYTES_PER_WORD = 4;
    localparam int DBG_CHECKSUM_BYTES = 1;

    // Serializer bit-level states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Frame sequencer states.
    typedef enum logic {
        FRAME_IDLE,
        FRAME_SEND
    } frame_state_e;

    // Total number of bytes in a frame carrying num_words state words.
    function automatic int dbg_frame_bytes(input int num_words);
        return DBG_HEADER_BYTES + DBG_BYTES_PER_WORD * num_words + DBG_CHECKSUM_BYTES;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Accepts one byte per valid/ready handshake and
// holds each bit on tx for CLKS_PER_BIT cycles. byte_ready is raised in
// the final cycle of the stop bit so a waiting byte starts with no gap.
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_last;

    assign baud_last  = (baud_q == BAUD_LAST);
    assign byte_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_last);
    assign tx         = tx_q;

    // Bit FSM: advances on baud boundaries and pre-computes the next tx level
    // so the line is driven straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (byte_valid) begin
                    state_d = TX_START;
                    baud_d  = '0;
                    shift_d = byte_data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_valid) begin
                        state_d = TX_START;
                        shift_d = byte_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer registers with synchronous active-low reset; line idles high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on start, sends header, NUM_WORDS state words
// (MSB first) and an XOR checksum of the data bytes as one gapless burst.
// Words are fetched through word_index/word_data; each word is latched as
// its first byte is handed to the serializer.
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NUM_WORDS    = 32,
    parameter int WIDX         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic [WIDX-1:0] word_index,
    input  logic [31:0]     word_data,
    output logic            tx,
    output logic            busy,
    output logic            done
);

    localparam int LAST_BYTE = dbg_frame_bytes(NUM_WORDS) - 1;
    localparam int CW        = $clog2(LAST_BYTE + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST_BYTE);
    localparam logic [CW-1:0] END_CNT  = CW'(LAST_BYTE + 1);
    localparam logic [CW-1:0] DATA_END = CW'(DBG_BYTES_PER_WORD * NUM_WORDS);

    frame_state_e    frame_q, frame_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]     word_q, word_d;
    logic [7:0]      chk_q, chk_d;
    logic [WIDX-1:0] word_idx_q, word_idx_d;
    logic            done_q, done_d;

    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            byte_accept;
    logic            is_data;
    logic [1:0]      lane;

    // Data bytes occupy indices 1..4*NUM_WORDS; lane 0 is each word's MSB.
    assign is_data     = (byte_cnt_q != '0) && (byte_cnt_q <= DATA_END);
    assign lane        = byte_cnt_q[1:0] - 2'd1;
    assign byte_accept = byte_valid && byte_ready;

    assign busy       = (frame_q == FRAME_SEND);
    assign done       = done_q;
    assign word_index = word_idx_q;

    // Pick the byte offered to the serializer. A word's MSB comes straight
    // from word_data because the word register is loaded on that same edge.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = DBG_FRAME_HEADER;
        if (frame_q == FRAME_IDLE) begin
            byte_valid = start;
        end else begin
            byte_valid = (byte_cnt_q <= LAST_CNT);
            if (byte_cnt_q == LAST_CNT) begin
                byte_data = chk_q;
            end else if (is_data) begin
                case (lane)
                    2'd0:    byte_data = word_data[31:24];
                    2'd1:    byte_data = word_q[23:16];
                    2'd2:    byte_data = word_q[15:8];
                    default: byte_data = word_q[7:0];
                endcase
            end
        end
    end

    // Frame sequencer: counts bytes, captures words, folds the checksum and
    // advances word_index one byte ahead of the word that needs it.
    always_comb begin
        frame_d    = frame_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        chk_d      = chk_q;
        word_idx_d = word_idx_q;
        done_d     = 1'b0;
        case (frame_q)
            FRAME_IDLE: begin
                if (byte_accept) begin
                    frame_d    = FRAME_SEND;
                    byte_cnt_d = CW'(1);
                    chk_d      = 8'h00;
                    word_idx_d = '0;
                end
            end
            FRAME_SEND: begin
                if (byte_accept) begin
                    byte_cnt_d = byte_cnt_q + CW'(1);
                    if (is_data) begin
                        chk_d = chk_q ^ byte_data;
                    end
                    if (is_data && (lane == 2'd0)) begin
                        word_d = word_data;
                    end
                    if ((byte_cnt_q[1:0] == 2'b00) && (byte_cnt_q < DATA_END)) begin
                        word_idx_d = WIDX'(byte_cnt_q >> 2);
                    end
                end else if ((byte_cnt_q == END_CNT) && byte_ready) begin
                    frame_d    = FRAME_IDLE;
                    done_d     = 1'b1;
                    word_idx_d = '0;
                end
            end
            default: begin
                frame_d = FRAME_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous active-low reset; a reset mid
    // frame abandons it without a done pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_q    <= FRAME_IDLE;
            byte_cnt_q <= '0;
            word_q     <= 32'h0;
            chk_q      <= 8'h00;
            word_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            word_idx_q <= word_idx_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx)
    );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected frame bytes are queued when
// a frame is requested and a UART decoder on tx pops and compares them.
module tb_debug_dump_tx;

    localparam int CPB = 4;
    localparam int NW  = 2;
    localparam int FRAME_CYCLES = (4 * NW + 2) * 10 * CPB;

    localparam logic [7:0] EXP_FRAME [10] = '{
        8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66
    };

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [0:0]  word_index;
    logic [31:0] word_data;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        tx;
    logic        busy;
    logic        done;

    logic [7:0]  exp_q [$];
    int n_checks = 0;
    int n_fails  = 0;
    int cycle    = 0;
    int done_count  = 0;
    int done_cycle  = 0;
    int busy_cycles = 0;

    bit         mon_active   = 1'b0;
    bit         mon_hold_err = 1'b0;
    int         mon_cnt      = 0;
    int         mon_prev_end = 0;
    int         frame_byte_idx = 0;
    logic [9:0] mon_bits     = '0;

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    assign word_data = (word_index == 1'b0) ? w0 : w1;

    debug_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_WORDS   (NW),
        .WIDX        (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .word_index (word_index),
        .word_data  (word_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    // Monitor: decodes tx at negedge, checks bit hold, gaps and frame bytes.
    always @(negedge clock) begin
        if (!reset_n) begin
            mon_active     = 1'b0;
            frame_byte_idx = 0;
        end else begin
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                done_cycle     = cycle;
                frame_byte_idx = 0;
                checkOutput("done_busy_low", {31'd0, busy}, 32'd0);
                checkOutput("done_tx_idle", {31'd0, tx}, 32'd1);
            end
            if (!mon_active && tx == 1'b0) begin
                mon_active   = 1'b1;
                mon_cnt      = 0;
                mon_hold_err = 1'b0;
                mon_bits     = '0;
                if (frame_byte_idx > 0)
                    checkOutput("byte_gap", cycle, mon_prev_end + 1);
            end
            if (mon_active) begin
                if (mon_cnt % CPB == 0)
                    mon_bits[mon_cnt / CPB] = tx;
                else if (tx !== mon_bits[mon_cnt / CPB])
                    mon_hold_err = 1'b1;
                mon_cnt++;
                if (mon_cnt == 10 * CPB) begin
                    mon_active   = 1'b0;
                    mon_prev_end = cycle;
                    frame_byte_idx++;
                    checkOutput("bit_hold", {31'd0, mon_hold_err}, 32'd0);
                    checkOutput("stop_bit", {31'd0, mon_bits[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_byte", {24'd0, mon_bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("frame_byte", {24'd0, mon_bits[8:1]},
                                    {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_frame();
        foreach (EXP_FRAME[i]) exp_q.push_back(EXP_FRAME[i]);
    endtask

    // Queue one expected frame and pulse start; k is the cycle start is high.
    task automatic applyStimulus(output int k);
        push_frame();
        k     = cycle;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  k;
        int  d1;
        int  dc0;
        bit  ok;
        bit  seen;

        reset_n = 1'b0;
        start   = 1'b0;
        w0      = 32'h11223344;
        w1      = 32'hDEADBEEF;
        wait_cycles(3);
        @(negedge clock);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_word_index", {31'd0, word_index}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_cycles(2);

        $display("[TB] basic frame");
        busy_cycles = 0;
        applyStimulus(k);
        @(negedge clock);
        checkOutput("busy_at_k1", {31'd0, busy}, 32'd1);
        checkOutput("start_bit_at_k1", {31'd0, tx}, 32'd0);
        wait_done(1000, ok);
        checkOutput("frame_end_cycle", cycle, k + FRAME_CYCLES + 1);
        checkOutput("busy_cycles", busy_cycles, FRAME_CYCLES);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("word_index_after_done", {31'd0, word_index}, 32'd0);
        @(negedge clock);
        checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
        wait_cycles(3);

        $display("[TB] word change during captured bytes");
        applyStimulus(k);
        wait_cycles(249);
        w1 = 32'h0;
        wait_done(1000, ok);
        w1 = 32'hDEADBEEF;
        checkOutput("late_change_drained", exp_q.size(), 0);
        wait_cycles(3);

        $display("[TB] word presented after word_index");
        w1 = 32'h0;
        applyStimulus(k);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (word_index == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("word_index_seen", {31'd0, seen}, 32'd1);
        checkOutput("word_index_cycle", cycle, k + 161);
        w1 = 32'hDEADBEEF;
        wait_done(1000, ok);
        checkOutput("late_present_drained", exp_q.size(), 0);
        wait_cycles(3);

        $display("[TB] start while busy");
        dc0 = done_count;
        applyStimulus(k);
        wait_cycles(99);
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_done(1000, ok);
        wait_cycles(450);
        checkOutput("busy_start_one_done", done_count - dc0, 1);
        checkOutput("busy_start_idle", {31'd0, busy}, 32'd0);
        checkOutput("busy_start_drained", exp_q.size(), 0);

        $display("[TB] reset mid-frame");
        dc0 = done_count;
        applyStimulus(k);
        wait_cycles(149);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(20);
        checkOutput("midreset_no_done", done_count - dc0, 0);
        busy_cycles = 0;
        applyStimulus(k);
        wait_done(1000, ok);
        checkOutput("post_reset_end_cycle", cycle, k + FRAME_CYCLES + 1);
        checkOutput("post_reset_busy_cycles", busy_cycles, FRAME_CYCLES);
        checkOutput("post_reset_drained", exp_q.size(), 0);
        wait_cycles(3);

        $display("[TB] back-to-back frames");
        dc0 = done_count;
        push_frame();
        push_frame();
        k     = cycle;
        start = 1'b1;
        wait_done(1000, ok);
        d1 = cycle;
        checkOutput("b2b_first_end", d1, k + FRAME_CYCLES + 1);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(1000, ok);
        checkOutput("b2b_period", cycle - d1, FRAME_CYCLES + 1);
        wait_cycles(50);
        checkOutput("b2b_done_count", done_count - dc0, 2);
        checkOutput("b2b_idle", {31'd0, busy}, 32'd0);
        checkOutput("b2b_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
